// File: rtl/bus_client_port.sv
// Client-side bus front end: queues client commands, requests the arbiter for
// the oldest one, holds the bus until the server acks, and returns read data.
module bus_client_port #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cl_valid,
  output logic                          cl_ready,
  input  logic                          cl_wr,
  input  logic [ADDR_WIDTH-1:0]         cl_addr,
  input  logic [DATA_WIDTH-1:0]         cl_wdata,
  output logic [DATA_WIDTH-1:0]         cl_rdata,
  output logic                          cl_rvalid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          arb_req,
  input  logic                          arb_gnt,
  output logic                          arb_wr,
  output logic [ADDR_WIDTH-1:0]         arb_addr,
  output logic [DATA_WIDTH-1:0]         arb_wdata,
  input  logic [DATA_WIDTH-1:0]         arb_rdata,
  input  logic                          arb_ack
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY} state_t;

  cmd_t            mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  state_t          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic            full, push, pop;
  cmd_t            cl_entry;

  // Acceptance looks only at registered occupancy, so a full FIFO refuses a
  // push even when the head is popped in the same cycle.
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign push     = cl_valid && !full;
  assign pop      = (state_q == S_BUSY) && arb_ack;
  assign cl_entry = '{wr: cl_wr, addr: cl_addr, wdata: cl_wdata};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PW'(1);
    if (pop)  rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        cmd_d   = mem_q[rptr_q];
        state_d = S_REQ;
      end
      S_REQ:  if (arb_gnt) state_d = S_BUSY;
      // Always drop back to IDLE so the arbiter sees req low for a cycle.
      S_BUSY: if (arb_ack) begin
        state_d = S_IDLE;
        if (!cmd_q.wr) begin
          rvalid_d = 1'b1;
          rdata_d  = arb_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= cl_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cl_ready   = !full;
  assign fifo_count = count_q;
  assign arb_req    = (state_q != S_IDLE);
  assign arb_wr     = cmd_q.wr;
  assign arb_addr   = cmd_q.addr;
  assign arb_wdata  = cmd_q.wdata;
  assign cl_rvalid  = rvalid_q;
  assign cl_rdata   = rdata_q;
endmodule
